// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control unit of the multicycle MIPS core.
// A Moore FSM sequences fetch/decode/execute/memory/write-back. Its control
// word is registered alongside the state. The ALU decoder turns alu_op and
// funct into the ALU function code.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       branch;
        logic       instr_done;
    } ctrl_t;

    state_t     r_state;
    ctrl_t      r_ctrl;
    state_t     w_next;
    logic       w_illegal;
    logic [2:0] w_alu_control;

    function automatic logic op_supported(input logic [5:0] opc);
        op_supported = (opc == OP_LW) || (opc == OP_SW) || (opc == OP_RTYPE) ||
                       (opc == OP_BEQ) || (opc == OP_ADDI) || (opc == OP_J);
    endfunction

    // Unused encodings 12-15 fall through to the default and recover to FETCH.
    function automatic state_t next_state(input state_t s, input logic [5:0] opc);
        next_state = S_FETCH;
        case (s)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    endfunction

    // Control word asserted while the FSM sits in state s.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b = 2'b01;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = 1'b1;
                c.alu_op     = 2'b01;
                c.pc_src     = 2'b01;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; op is only meaningful in DECODE and MEMADR.
    always_comb begin
        w_next = next_state(r_state, op);
    end

    // State register with the control word registered for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

    // ALU decoder: funct only matters when the FSM requests an R-type operation.
    always_comb begin
        w_alu_control = 3'b010;
        case (r_ctrl.alu_op)
            2'b00: w_alu_control = 3'b010;
            2'b01: w_alu_control = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: w_alu_control = 3'b010;
                    6'b100010: w_alu_control = 3'b110;
                    6'b100100: w_alu_control = 3'b000;
                    6'b100101: w_alu_control = 3'b001;
                    6'b101010: w_alu_control = 3'b111;
                    default:   w_alu_control = 3'b010;
                endcase
            end
            default: w_alu_control = 3'b010;
        endcase
    end

    assign w_illegal = (r_state == S_DECODE) && !op_supported(op);

    // Write enables are squashed while reset is held so an aborted
    // instruction cannot commit anything.
    assign pc_en       = ~reset & (r_ctrl.pc_write | (r_ctrl.branch & zero));
    assign iord        = r_ctrl.iord;
    assign mem_write   = ~reset & r_ctrl.mem_write;
    assign ir_write    = ~reset & r_ctrl.ir_write;
    assign reg_dst     = r_ctrl.reg_dst;
    assign mem_to_reg  = r_ctrl.mem_to_reg;
    assign reg_write   = ~reset & r_ctrl.reg_write;
    assign alu_src_a   = r_ctrl.alu_src_a;
    assign alu_src_b   = r_ctrl.alu_src_b;
    assign pc_src      = r_ctrl.pc_src;
    assign alu_control = w_alu_control;
    assign instr_done  = r_ctrl.instr_done;
    assign illegal_op  = ~reset & w_illegal;
    assign state       = r_state;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle MIPS core. A Moore state machine sequences instruction fetch from the instruction ROM, decode, execute, memory access and write-back, and drives every datapath mux select and write enable. It also holds the ALU decoder. It supports lw, sw, R-type (add, sub, and, or, slt), beq, addi and j; any other opcode is flagged and skipped.

## Interface
- No parameters. Opcode and state encodings are fixed.
- `clk`  in  1  single system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; forces the state to FETCH on the next rising edge
- `op`  in  6  instruction[31:26] taken from the instruction register
- `funct`  in  6  instruction[5:0] taken from the instruction register
- `zero`  in  1  ALU zero flag
- `pc_en`  out  1  PC register enable; equals `pc_write | (branch & zero)`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  data memory write enable
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  register-file write address: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  register-file write data: 0 = ALUOut, 1 = memory data
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  1  ALU A operand: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU B operand: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_control`  out  3  ALU function code
- `instr_done`  out  1  high during the final state of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- `state`  out  4  current state, for debug and verification

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw(100011) and sw(101011)→MEMADR; R-type(000000)→EXECUTE; beq(000100)→BEQ; addi(001000)→ADDIEX; j(000010)→JUMP; any other opcode→FETCH with `illegal_op`=1.
  - MEMADR→MEMRD if op is lw, otherwise →MEMWR.
  - MEMRD→MEMWB.
  - EXECUTE→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BEQ, ADDIWB, JUMP→FETCH.
- Outputs per state. Every output not listed is 0.
  - FETCH: `alu_src_b`=01, `ir_write`=1, `pc_write`=1.
  - DECODE: `alu_src_b`=11.
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `mem_to_reg`=1, `reg_write`=1.
  - MEMWR: `iord`=1, `mem_write`=1.
  - EXECUTE: `alu_src_a`=1, `alu_op`=10.
  - ALUWB: `reg_dst`=1, `reg_write`=1.
  - BEQ: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `branch`=1.
  - ADDIWB: `reg_write`=1.
  - JUMP: `pc_src`=10, `pc_write`=1.
- `alu_op` is a 2-bit internal signal; `alu_control` is decoded combinationally from it:
  - `alu_op`=00 → 010 (add); 01 → 110 (sub).
  - `alu_op`=10, decoded from `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct→010.
- `instr_done` is high in MEMWB, MEMWR, ALUWB, BEQ, ADDIWB and JUMP.
- `op` is sampled only in DECODE and MEMADR. Because the IR holds it stable for the rest of the instruction, no internal copy of `op` is kept.

## Timing
- All control outputs are Moore outputs of the state register. The only exceptions are `pc_en`, which also depends on `zero`, and `alu_control` in EXECUTE, which depends on `funct`.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Reset:
  - While `reset`=1, `pc_en`, `ir_write`, `reg_write`, `mem_write` and `illegal_op` are forced to 0 combinationally.
  - On the first edge with `reset`=1, `state` becomes 0 (FETCH).
  - On the first cycle after `reset` falls, FETCH outputs are active.
- Reset in the middle of an instruction aborts it. No write enable is asserted in the cycle where `reset` is high.
- In BEQ, `pc_en` follows `zero` within the same cycle. If `zero` changes within BEQ, `pc_en` follows it, and the value at the clock edge is the one that takes effect.
- `illegal_op` is never high outside DECODE.

## Test plan
- Reset, then lw (op=100011): `state` sequence 0,1,2,3,4,0. `iord`=1 in state 3. `reg_write`=1 and `mem_to_reg`=1 only in state 4. `instr_done` is high for exactly 1 cycle.
- R-type with funct=101010: states 0,1,6,7. In state 6, `alu_control`=111. In state 7, `reg_dst`=1 and `reg_write`=1. Repeat for the other four functs, checking 010, 110, 000 and 001.
- beq with `zero`=1: `pc_en`=1 and `pc_src`=01 in state 8. Repeat with `zero`=0: `pc_en`=0 in state 8. Both return to state 0 after 3 cycles.
- sw, addi and j back-to-back: sw gives `mem_write`=1 only in state 5; addi gives `reg_write`=1 with `reg_dst`=0 in state 10; j gives `pc_en`=1 and `pc_src`=10 in state 11. Total is 11 cycles.
- op=111111: `illegal_op`=1 for 1 cycle in state 1. The next state is 0, and no write enable other than FETCH's is asserted.
- `reset`=1 asserted during MEMWR: `mem_write`=0 in that cycle, `state`=0 after the edge, and a normal FETCH follows when `reset` is released.
